// File: rtl/codec_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codec_regs_pkg
// Description : WM8731-class codec register map: register indices, power-on
//               defaults and the I2C target FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package codec_regs_pkg;

    localparam logic [6:0] c_LINVOL = 7'h00;
    localparam logic [6:0] c_RINVOL = 7'h01;
    localparam logic [6:0] c_LHPOUT = 7'h02;
    localparam logic [6:0] c_RHPOUT = 7'h03;
    localparam logic [6:0] c_APANA  = 7'h04;
    localparam logic [6:0] c_APDIG  = 7'h05;
    localparam logic [6:0] c_POWER  = 7'h06;
    localparam logic [6:0] c_IFACE  = 7'h07;
    localparam logic [6:0] c_SRATE  = 7'h08;
    localparam logic [6:0] c_ACTIVE = 7'h09;
    localparam logic [6:0] c_RESET  = 7'h0F;

    localparam int c_NUM_DEFAULTS = 10;

    // Indexed by register number, LINVOL first.
    localparam logic [8:0] c_REG_DEFAULTS [c_NUM_DEFAULTS] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK_A  = 3'd2,
        ST_BYTE0  = 3'd3,
        ST_ACK_0  = 3'd4,
        ST_BYTE1  = 3'd5,
        ST_ACK_1  = 3'd6,
        ST_IGNORE = 3'd7
    } i2c_state_e;

    function automatic logic [8:0] reg_default(input logic [6:0] idx);
        if (idx <= c_ACTIVE) begin
            return c_REG_DEFAULTS[idx[3:0]];
        end
        return 9'h000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_filter
// Description : 2-flop synchronizer, optional glitch filter (I2C_TARGET_FILTER_EN)
//               and registered rise/fall detect for one I2C line.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

`ifdef I2C_TARGET_FILTER_EN
    localparam bit c_FILTER_ON = 1'b1;
`else
    localparam bit c_FILTER_ON = 1'b0;
`endif

    logic [1:0] r_sync;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;
    logic       w_next_level;

    // Idle bus level is high, so reset never produces a spurious edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], line_in};
        end
    end

    generate
        if (c_FILTER_ON && FILTER_LEN > 1) begin : g_filter
            logic [FILTER_LEN-1:0] r_hist;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_hist <= '1;
                end else begin
                    r_hist <= {r_hist[FILTER_LEN-2:0], r_sync[1]};
                end
            end

            always_comb begin
                w_next_level = r_level;
                if (&r_hist) begin
                    w_next_level = 1'b1;
                end else if (~|r_hist) begin
                    w_next_level = 1'b0;
                end
            end
        end else begin : g_bypass
            assign w_next_level = r_sync[1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_level <= w_next_level;
            r_rise  <= w_next_level & ~r_level;
            r_fall  <= ~w_next_level & r_level;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/i2c_codec_target.sv
`default_nettype none
// ============================================================================
// Module      : i2c_codec_target
// Description : Write-only I2C target holding a WM8731-class codec register
//               file. Glitch filter enabled by defining I2C_TARGET_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_codec_target
    import codec_regs_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         NUM_REGS   = 10,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    input  logic       i2c_sdat_in,
    output logic       i2c_sdat_oe,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       write_valid,
    output logic [6:0] write_addr,
    output logic [8:0] write_data,
    output logic       bad_addr
);

    localparam logic [2:0] c_ST_IDLE   = ST_IDLE;
    localparam logic [2:0] c_ST_ADDR   = ST_ADDR;
    localparam logic [2:0] c_ST_ACK_A  = ST_ACK_A;
    localparam logic [2:0] c_ST_BYTE0  = ST_BYTE0;
    localparam logic [2:0] c_ST_ACK_0  = ST_ACK_0;
    localparam logic [2:0] c_ST_BYTE1  = ST_BYTE1;
    localparam logic [2:0] c_ST_ACK_1  = ST_ACK_1;
    localparam logic [2:0] c_ST_IGNORE = ST_IGNORE;

    logic       w_scl_level, w_scl_rise, w_scl_fall;
    logic       w_sda_level, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop, w_reg_hit;
    logic [7:0] w_byte;
    logic [8:0] w_rd_data;

    logic [2:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       r_ack_drv;
    logic       r_oe;
    logic [6:0] r_reg_idx;
    logic [8:0] r_data;
    logic       r_write_valid;
    logic       r_bad_addr;
    logic [6:0] r_write_addr;
    logic [8:0] r_write_data;
    logic [8:0] r_regs [NUM_REGS];

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk     (clk),
        .reset   (reset),
        .line_in (i2c_sclk),
        .level   (w_scl_level),
        .rise    (w_scl_rise),
        .fall    (w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk     (clk),
        .reset   (reset),
        .line_in (i2c_sdat_in),
        .level   (w_sda_level),
        .rise    (w_sda_rise),
        .fall    (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl_level;
    assign w_stop  = w_sda_rise & w_scl_level;
    assign w_byte  = {r_shift, w_sda_level};

    always_comb begin
        w_reg_hit = 1'b0;
        w_rd_data = 9'h000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_reg_idx == 7'(i)) begin
                w_reg_hit = 1'b1;
            end
            if (rd_addr == 4'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 7'd0;
            r_ack_drv     <= 1'b0;
            r_oe          <= 1'b0;
            r_reg_idx     <= 7'd0;
            r_data        <= 9'd0;
            r_write_valid <= 1'b0;
            r_bad_addr    <= 1'b0;
            r_write_addr  <= 7'd0;
            r_write_data  <= 9'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= reg_default(7'(i));
            end
        end else begin
            r_write_valid <= 1'b0;
            r_bad_addr    <= 1'b0;
            if (w_stop) begin
                r_state   <= c_ST_IDLE;
                r_bit_cnt <= 3'd0;
                r_ack_drv <= 1'b0;
                r_oe      <= 1'b0;
            end else if (w_start) begin
                r_state   <= c_ST_ADDR;
                r_bit_cnt <= 3'd0;
                r_ack_drv <= 1'b0;
                r_oe      <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_ADDR, c_ST_BYTE0, c_ST_BYTE1: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_state == c_ST_ADDR) begin
                                    r_state <= (w_byte[7:1] == DEV_ADDR && !w_byte[0])
                                               ? c_ST_ACK_A : c_ST_IGNORE;
                                end else if (r_state == c_ST_BYTE0) begin
                                    r_reg_idx <= w_byte[7:1];
                                    r_data[8] <= w_byte[0];
                                    r_state   <= c_ST_ACK_0;
                                end else begin
                                    r_data[7:0] <= w_byte;
                                    r_state     <= c_ST_ACK_1;
                                end
                            end
                        end
                    end
                    c_ST_ACK_A, c_ST_ACK_0, c_ST_ACK_1: begin
                        // First fall after the 8th bit drives ACK, the next one releases it.
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                r_oe      <= 1'b1;
                                r_ack_drv <= 1'b1;
                            end else begin
                                r_oe      <= 1'b0;
                                r_ack_drv <= 1'b0;
                                if (r_state == c_ST_ACK_A) begin
                                    r_state <= c_ST_BYTE0;
                                end else if (r_state == c_ST_ACK_0) begin
                                    r_state <= c_ST_BYTE1;
                                end else begin
                                    r_state       <= c_ST_IGNORE;
                                    r_write_addr  <= r_reg_idx;
                                    r_write_data  <= r_data;
                                    r_write_valid <= 1'b1;
                                    if (r_reg_idx == c_RESET) begin
                                        for (int i = 0; i < NUM_REGS; i++) begin
                                            r_regs[i] <= reg_default(7'(i));
                                        end
                                    end else if (w_reg_hit) begin
                                        for (int i = 0; i < NUM_REGS; i++) begin
                                            if (r_reg_idx == 7'(i)) begin
                                                r_regs[i] <= r_data;
                                            end
                                        end
                                    end else begin
                                        r_bad_addr <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i2c_sdat_oe = r_oe;
    assign rd_data     = w_rd_data;
    assign write_valid = r_write_valid;
    assign write_addr  = r_write_addr;
    assign write_data  = r_write_data;
    assign bad_addr    = r_bad_addr;

endmodule
`default_nettype wire
